// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the dual-read-port RAM arbiter.
package ram_arb_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 16;
   localparam int unsigned ADDR_WIDTH_DEF = 4;
   localparam int unsigned LAST_ADDR      = 8;

   typedef enum logic {INIT, ARB} arb_state_e;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/ram_dual_port_arbiter_if.sv
// Requester and RAM-side bus of the arbiter; slave is the arbiter view, master the client view.
interface ram_dual_port_arbiter_if #(
   parameter int unsigned DATA_WIDTH         = 16,
   parameter int unsigned ADDR_WIDTH_MAX_USE = 4
);
   logic                          iClear;
   logic                          oInitDone;
   logic                          iReqValid_A,  iReqValid_B;
   logic                          iReqWrite_A,  iReqWrite_B;
   logic [ADDR_WIDTH_MAX_USE-1:0] iReqAddr0_A,  iReqAddr0_B;
   logic [ADDR_WIDTH_MAX_USE-1:0] iReqAddr1_A,  iReqAddr1_B;
   logic [DATA_WIDTH-1:0]         iReqData_A,   iReqData_B;
   logic                          oReqReady_A,  oReqReady_B;
   logic                          oRspValid_A,  oRspValid_B;
   logic [DATA_WIDTH-1:0]         oRspData0,    oRspData1;
   logic                          oRamWriteEnable;
   logic [ADDR_WIDTH_MAX_USE-1:0] oRamWriteAddress;
   logic [ADDR_WIDTH_MAX_USE-1:0] oRamReadAddress0, oRamReadAddress1;
   logic [DATA_WIDTH-1:0]         oRamDataIn;
   logic [DATA_WIDTH-1:0]         iRamDataOut0, iRamDataOut1;

   modport slave (
      input  iClear, iReqValid_A, iReqValid_B, iReqWrite_A, iReqWrite_B,
             iReqAddr0_A, iReqAddr0_B, iReqAddr1_A, iReqAddr1_B, iReqData_A, iReqData_B,
             iRamDataOut0, iRamDataOut1,
      output oInitDone, oReqReady_A, oReqReady_B, oRspValid_A, oRspValid_B,
             oRspData0, oRspData1, oRamWriteEnable, oRamWriteAddress,
             oRamReadAddress0, oRamReadAddress1, oRamDataIn
   );

   modport master (
      output iClear, iReqValid_A, iReqValid_B, iReqWrite_A, iReqWrite_B,
             iReqAddr0_A, iReqAddr0_B, iReqAddr1_A, iReqAddr1_B, iReqData_A, iReqData_B,
             iRamDataOut0, iRamDataOut1,
      input  oInitDone, oReqReady_A, oReqReady_B, oRspValid_A, oRspValid_B,
             oRspData0, oRspData1, oRamWriteEnable, oRamWriteAddress,
             oRamReadAddress0, oRamReadAddress1, oRamDataIn
   );
endinterface

// File: rtl/ram_init_sequencer.sv
// Zero-fill address sequencer: busy out of reset, re-armed by i_start, o_done on the last address.
module ram_init_sequencer
   import ram_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned MEM_SIZE   = LAST_ADDR
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [ADDR_WIDTH-1:0] o_addr
);
   logic                  r_busy;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  w_last;

   assign w_last = (r_addr == ADDR_WIDTH'(MEM_SIZE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b1;
         r_addr <= '0;
      end else if (r_busy) begin
         if (w_last) begin
            r_busy <= 1'b0;
            r_addr <= '0;
         end else begin
            r_addr <= r_addr + 1'b1;
         end
      end else if (i_start) begin
         r_busy <= 1'b1;
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_busy & w_last;
   assign o_addr = r_addr;
endmodule

// File: rtl/ram_dual_port_arbiter.sv
// Round-robin arbiter sharing a 1W/2R RAM between requesters A and B, with zero-fill on reset/iClear.
// Optional same-cycle write+read issue is enabled by defining RAM_ARB_DUAL_ISSUE_EN.
module ram_dual_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH         = DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH_MAX_USE = ADDR_WIDTH_DEF,
   parameter int unsigned MEM_SIZE           = LAST_ADDR
) (
   input logic                     Clock,
   input logic                     Reset,
   ram_dual_port_arbiter_if.slave  bus
);
   arb_state_e                    r_state;
   logic                          r_init_done;
   logic                          r_ptr;
   logic                          r_rsp_valid;
   logic                          r_rsp_owner;
   logic [ADDR_WIDTH_MAX_USE-1:0] r_rd_addr0, r_rd_addr1;

   logic                          w_seq_busy, w_seq_done, w_seq_start;
   logic [ADDR_WIDTH_MAX_USE-1:0] w_seq_addr;
   logic                          w_arb, w_dual;
   logic                          w_gnt_a, w_gnt_b;
   logic                          w_wr_a, w_wr_b, w_rd_a, w_rd_b, w_rd;
   logic [ADDR_WIDTH_MAX_USE-1:0] w_rd_addr0, w_rd_addr1;

   assign w_seq_start = (r_state == ARB) & bus.iClear;

   ram_init_sequencer #(
      .ADDR_WIDTH (ADDR_WIDTH_MAX_USE),
      .MEM_SIZE   (MEM_SIZE)
   ) u_init_seq (
      .clk     (Clock),
      .rst_n   (Reset),
      .i_start (w_seq_start),
      .o_busy  (w_seq_busy),
      .o_done  (w_seq_done),
      .o_addr  (w_seq_addr)
   );

   assign w_arb = (r_state == ARB) & ~bus.iClear;
`ifdef RAM_ARB_DUAL_ISSUE_EN
   assign w_dual = bus.iReqValid_A & bus.iReqValid_B & (bus.iReqWrite_A ^ bus.iReqWrite_B);
`else
   assign w_dual = 1'b0;
`endif

   assign w_gnt_a = w_arb & bus.iReqValid_A & (~bus.iReqValid_B | w_dual | (r_ptr == REQ_A));
   assign w_gnt_b = w_arb & bus.iReqValid_B & (~bus.iReqValid_A | w_dual | (r_ptr == REQ_B));
   assign w_wr_a  = w_gnt_a & bus.iReqWrite_A;
   assign w_wr_b  = w_gnt_b & bus.iReqWrite_B;
   assign w_rd_a  = w_gnt_a & ~bus.iReqWrite_A;
   assign w_rd_b  = w_gnt_b & ~bus.iReqWrite_B;
   assign w_rd    = w_rd_a | w_rd_b;

   always_comb begin
      bus.oRamWriteEnable  = 1'b0;
      bus.oRamWriteAddress = w_seq_addr;
      bus.oRamDataIn       = DATA_WIDTH'(0);
      w_rd_addr0           = r_rd_addr0;
      w_rd_addr1           = r_rd_addr1;
      if (r_state == INIT) begin
         bus.oRamWriteEnable = w_seq_busy;
      end else if (w_wr_a) begin
         bus.oRamWriteEnable  = 1'b1;
         bus.oRamWriteAddress = bus.iReqAddr0_A;
         bus.oRamDataIn       = bus.iReqData_A;
      end else if (w_wr_b) begin
         bus.oRamWriteEnable  = 1'b1;
         bus.oRamWriteAddress = bus.iReqAddr0_B;
         bus.oRamDataIn       = bus.iReqData_B;
      end
      if (w_rd_a) begin
         w_rd_addr0 = bus.iReqAddr0_A;
         w_rd_addr1 = bus.iReqAddr1_A;
      end else if (w_rd_b) begin
         w_rd_addr0 = bus.iReqAddr0_B;
         w_rd_addr1 = bus.iReqAddr1_B;
      end
   end

   assign bus.oRamReadAddress0 = w_rd_addr0;
   assign bus.oRamReadAddress1 = w_rd_addr1;
   assign bus.oReqReady_A      = w_gnt_a;
   assign bus.oReqReady_B      = w_gnt_b;
   assign bus.oInitDone        = r_init_done;
   assign bus.oRspValid_A      = r_rsp_valid & (r_rsp_owner == REQ_A);
   assign bus.oRspValid_B      = r_rsp_valid & (r_rsp_owner == REQ_B);
   assign bus.oRspData0        = bus.iRamDataOut0;
   assign bus.oRspData1        = bus.iRamDataOut1;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state     <= INIT;
         r_init_done <= 1'b0;
         r_ptr       <= REQ_A;
         r_rsp_valid <= 1'b0;
         r_rsp_owner <= REQ_A;
         r_rd_addr0  <= '0;
         r_rd_addr1  <= '0;
      end else begin
         r_rsp_valid <= w_rd;
         r_rsp_owner <= w_rd_b ? REQ_B : REQ_A;
         if (w_rd) begin
            r_rd_addr0 <= w_rd_addr0;
            r_rd_addr1 <= w_rd_addr1;
         end
         // A dual grant leaves the pointer where it was.
         if (w_gnt_a ^ w_gnt_b) r_ptr <= w_gnt_a ? REQ_B : REQ_A;
         case (r_state)
            INIT: if (w_seq_done) begin
               r_state     <= ARB;
               r_init_done <= 1'b1;
            end
            ARB: if (bus.iClear) begin
               r_state     <= INIT;
               r_init_done <= 1'b0;
            end
            default: r_state <= INIT;
         endcase
      end
   end
endmodule
